// File: rtl/div_ctrl_pkg.sv
// Shared state codes and handshake constants for the iterative divider.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_SIGNED           = 1'b1;
    localparam logic DIV_UNSIGNED         = 1'b0;

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, restore on borrow.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem_i,
    input  logic              dvd_msb_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W:0]   rem_o,
    output logic              q_o
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] diff;

    always_comb begin
        shifted = {rem_i, dvd_msb_i};
        diff    = shifted - {2'b00, dvs_i};
        q_o     = ~diff[DATA_W+1];
        rem_o   = q_o ? diff[DATA_W:0] : shifted[DATA_W:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// Radix-2 restoring DIV/DIVU sequencer returning {remainder, quotient}.
// DIV_EARLY_EXIT_EN: skip the loop when |dividend| < |divisor|.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    div_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvs;
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W:0]   rem_n;
    logic              q_bit;
    logic [DATA_W-1:0] quo_n;
    logic              is_signed;

    always_comb begin
        is_signed = (signed_div_i == DIV_SIGNED);
        mag1 = (is_signed && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        mag2 = (is_signed && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        quo_n = {dvd[DATA_W-2:0], q_bit};
    end

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i     (rem),
        .dvd_msb_i (dvd[DATA_W-1]),
        .dvs_i     (dvs),
        .rem_o     (rem_n),
        .q_o       (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            busy_o   <= 1'b0;
        end else begin
            unique case (state)
                DIV_FREE: begin
                    if (start_i == DIV_START && !annul_i) begin
                        busy_o <= 1'b1;
                        if (opdata2_i == '0) begin
                            state <= DIV_BYZERO;
`ifdef DIV_EARLY_EXIT_EN
                        end else if (mag1 < mag2) begin
                            state    <= DIV_END;
                            result_o <= {opdata1_i, {DATA_W{1'b0}}};
                            ready_o  <= DIV_RESULT_READY;
`endif
                        end else begin
                            state <= DIV_ON;
                            cnt   <= '0;
                            rem   <= '0;
                            dvd   <= mag1;
                            dvs   <= mag2;
                            neg_q <= is_signed
                                   & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_r <= is_signed & opdata1_i[DATA_W-1];
                        end
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state  <= DIV_FREE;
                        busy_o <= 1'b0;
                    end else begin
                        rem <= rem_n;
                        dvd <= quo_n;
                        cnt <= cnt + CNT_W'(1);
                        // Last step and sign fix share an edge so ready lands on cycle DATA_W+1.
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state    <= DIV_END;
                            ready_o  <= DIV_RESULT_READY;
                            result_o <= {neg_r ? -rem_n[DATA_W-1:0] : rem_n[DATA_W-1:0],
                                         neg_q ? -quo_n : quo_n};
                        end
                    end
                end
                DIV_BYZERO: begin
                    state    <= DIV_END;
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_READY;
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state   <= DIV_FREE;
                        ready_o <= DIV_RESULT_NOT_READY;
                        busy_o  <= 1'b0;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl against an arithmetic reference model.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic sgn, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [63:0] res, output int lat);
        longint sa, sb, q, m;
        if (b == 0) begin
            res = '0;
            lat = 2;
            return;
        end
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        q = sa / sb;
        m = sa % sb;
        res = {m[31:0], q[31:0]};
        lat = 33;
`ifdef DIV_EARLY_EXIT_EN
        if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) begin
            res = {a, 32'h0};
            lat = 1;
        end
`endif
    endfunction

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat;
        int n;
        model(sgn, a, b, exp, lat);
        signed_div_i = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) chk("busy_c1", busy_o, 1);
            opdata1_i = $urandom;
            opdata2_i = $urandom;
        end while (!ready_o && n < 60);
        chk("latency", n, lat);
        chk("result", result_o, exp);
        annul_i = 1'b1;
        tick();
        chk("end_ready", ready_o, 1);
        chk("end_hold", result_o, exp);
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        chk("drop_ready", ready_o, 0);
        chk("drop_busy", busy_o, 0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [63:0] keep;
        rst = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();
        tick();
        chk("rst_result", result_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_busy", busy_o, 0);
        rst = 1'b0;
        tick();

        do_div(1'b0, 32'd100, 32'd7);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div(1'b1, 32'd5, 32'd0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div(1'b0, 32'd3, 32'd10);
        do_div(1'b1, 32'hFFFF_FFFD, 32'd10);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1);

        // Annul in flight, then a fresh divide must still work.
        signed_div_i = 1'b0;
        opdata1_i = 32'hFFFF_FFFF;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (10) tick();
        annul_i = 1'b1;
        tick();
        chk("annul_busy", busy_o, 0);
        chk("annul_ready", ready_o, 0);
        start_i = 1'b0;
        annul_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) chk("annul_noready", ready_o, 0);
        end
        do_div(1'b0, 32'd9, 32'd3);

        // Start with annul in IDLE stays idle.
        start_i = 1'b1;
        annul_i = 1'b1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        tick();
        chk("idle_annul_busy", busy_o, 0);
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();

        // Reset mid-divide clears everything.
        keep = result_o;
        chk("pre_rst_result", keep, 64'h0000_0000_0000_0003);
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_result", result_o, 0);
        chk("mid_rst_ready", ready_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        rst = 1'b0;
        start_i = 1'b0;
        tick();

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = b >> $urandom_range(0, 31);
                2: a = a >> $urandom_range(0, 31);
                3: b = b | 32'h8000_0000;
                default: ;
            endcase
            do_div(1'($urandom_range(0, 1)), a, b);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
